latch_arbiter: RTL and testbench

- Round-robin arbiter that shares one W-bit enabled holding register (latch-style storage) between N requesters.
- The granted owner's data passes through the register one cycle late while it holds the grant.
- On release, the register freezes the last value, the same way an enable-low latch does.
- Sits between multiple producers and any downstream consumer of a single shared held value.

---
 rtl/latch_arbiter.sv | 112 +++++++++++
 tb/tb_latch_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/latch_arbiter.sv
// Round-robin arbiter that shares one held W-bit register between N requesters.
// Define LATCH_ARB_PRIO0_EN to give requester 0 fixed top priority in IDLE.
module latch_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         req,
  input  logic [N-1:0]                         rel,
  input  logic [N*W-1:0]                       d,
  output logic [N-1:0]                         gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
  output logic [W-1:0]                         q,
  output logic                                 q_valid,
  output logic                                 busy
);

  localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [N-1:0] OneHot0 = N'(1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e        state;
  logic [OW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [OW-1:0] sel, sel_hi, sel_lo, ptr_next;
  logic          found_hi;
  logic [W-1:0]  d_own;
  logic          req_own, rel_own, hold_hit, release_own;

  // Two passes: lowest set bit at or above ptr, else lowest set bit overall (wrap).
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        sel_lo = OW'(j);
        if (OW'(j) >= ptr) begin
          sel_hi   = OW'(j);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
`ifdef LATCH_ARB_PRIO0_EN
    if (req[0]) sel = '0;
`endif
  end

  always_comb begin
    d_own   = '0;
    req_own = 1'b0;
    rel_own = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (owner == OW'(j)) begin
        d_own   = d[j*W +: W];
        req_own = req[j];
        rel_own = rel[j];
      end
    end
  end

  assign hold_hit    = (HOLD_MAX != 0) && (cnt == CW'(HOLD_MAX));
  assign release_own = rel_own || !req_own || hold_hit;
  assign ptr_next    = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      gnt     <= '0;
      owner   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (|req) begin
            state <= StOwn;
            gnt   <= OneHot0 << sel;
            owner <= sel;
            busy  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        StOwn: begin
          if (release_own) begin
            // q is not loaded on the release edge, so it freezes at the prior value.
            state <= StIdle;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            cnt   <= '0;
          end else begin
            q       <= d_own;
            q_valid <= 1'b1;
            if (HOLD_MAX != 0 && cnt != CW'(HOLD_MAX)) cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_arbiter.sv
// Randomized bench for latch_arbiter checked cycle by cycle against a behavioural model.
module tb_latch_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int HOLD_MAX = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, rel;
  logic [N*W-1:0] d;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           q_valid, busy;

  int checks = 0;
  int failures = 0;

  // Model state as plain integers.
  int m_owner, m_ptr, m_cnt, m_q, m_qv, m_busy;

  always #5 clk = ~clk;

  latch_arbiter #(.N(N), .W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .rel(rel), .d(d),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef LATCH_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = 0; m_qv = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (req != 0) begin
        m_owner = pick(req, m_ptr);
        m_busy  = 1;
        m_cnt   = 1;
      end
    end else if (rel[m_owner] || !req[m_owner] || (HOLD_MAX != 0 && m_cnt == HOLD_MAX)) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
      m_cnt  = 0;
    end else begin
      m_q  = int'(d[m_owner*W +: W]);
      m_qv = 1;
      if (m_cnt < HOLD_MAX) m_cnt++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_gnt;
    exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("owner", 32'(owner), 32'(m_owner));
    check("q", 32'(q), 32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] rl,
                      input logic [N*W-1:0] dd);
    rst = r; req = rq; rel = rl; d = dd;
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    int hold_len;
    logic [N-1:0] rq, rl;
    logic [N*W-1:0] dd;

    m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = 0; m_qv = 0; m_busy = 0;
    step(1'b1, '0, '0, '0);
    step(1'b1, 4'b1111, 4'b1111, 32'hFFFF_FFFF);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_q", 32'(q), 32'h0);

    // Single requester: grant, load, release, freeze.
    step(1'b0, 4'b0001, '0, 32'h0000_00A5);
    check("t1_gnt", 32'(gnt), 32'h1);
    step(1'b0, 4'b0001, '0, 32'h0000_00A5);
    check("t1_q", 32'(q), 32'hA5);
    step(1'b0, 4'b0001, 4'b0001, 32'h0000_0011);
    check("t1_rel_busy", 32'(busy), 32'h0);
    step(1'b0, 4'b0000, '0, 32'h0000_0022);
    check("t1_frozen_q", 32'(q), 32'hA5);

    // Timeout: requester 2 held continuously.
    step(1'b1, '0, '0, '0);
    hold_len = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 4'b0100, '0, 32'($urandom));
      if (gnt[2]) hold_len++;
    end
    check("hold_len", 32'(hold_len), 32'(HOLD_MAX));
    check("hold_idle", 32'(gnt), 32'h0);
    step(1'b0, 4'b0110, '0, 32'($urandom));
    check("regrant_after_timeout", 32'(gnt), 32'b0010);

    // Non-owner release ignored.
    step(1'b1, '0, '0, '0);
    step(1'b0, 4'b1000, '0, 32'h3C00_0000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 4'b0010, 32'($urandom));
    check("nonowner_rel", 32'(gnt), 32'b1000);

    // Randomized traffic with sticky requests and rare rel/rst.
    rq = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) rq = N'($urandom);
      rl = ($urandom_range(0, 11) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      dd = 32'($urandom);
      step($urandom_range(0, 299) == 0, rq, rl, dd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
